// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader: packs field-level instruction requests into 16-bit words and loads them into imem
// Ports: clk, rst (sync, active-high); start re-arms from DONE; in_valid/in_ready/in_op/in_ra/in_rb/in_rc/
//   in_imm/in_last request stream; imem_we/imem_addr/imem_wdata registered write port; done, words,
//   err_range, err_ovf status. Define ENC_PAD_EN to HALT-fill imem above the program before done rises.
module instr_encoder_loader #(
  parameter int DEPTH = 256,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2:0]    in_op,
  input  logic [2:0]    in_ra,
  input  logic [2:0]    in_rb,
  input  logic [2:0]    in_rc,
  input  logic [9:0]    in_imm,
  input  logic          in_last,
  output logic          imem_we,
  output logic [AW-1:0] imem_addr,
  output logic [15:0]   imem_wdata,
  output logic          done,
  output logic [AW:0]   words,
  output logic          err_range,
  output logic          err_ovf
);
  typedef enum logic [1:0] {
    RUN,
`ifdef ENC_PAD_EN
    PAD,
`endif
    DONE
  } state_t;
  localparam logic [AW-1:0] top_addr = AW'(DEPTH - 1);
  state_t state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d, addr_q, addr_d;
  logic [AW:0] words_q, words_d;
  logic [15:0] wdata_q, wdata_d, enc;
  logic we_q, we_d, rdy_q, rdy_d, done_q, done_d, erng_q, erng_d, eovf_q, eovf_d;
  logic rri, in_rng, acc;
  always_comb begin
    rri = in_op inside {3'd3, 3'd4, 3'd5};
    // fits in simm7 only when bits 9:6 are all copies of the simm7 sign bit
    in_rng = in_imm[9:6] == {4{in_imm[6]}};
    enc = in_op == 3'd6 ? 16'hC000 :
          in_op == 3'd7 ? 16'hE000 :
          in_op == 3'd2 ? {in_op, in_ra, in_imm} :
          rri ? {in_op, in_ra, in_rb, in_imm[6:0]} : {in_op, in_ra, in_rb, 4'b0, in_rc};
    acc = in_valid && rdy_q;
    state_d = state_q;
    ptr_d = ptr_q;
    words_d = words_q;
    we_d = 1'b0;
    addr_d = addr_q;
    wdata_d = wdata_q;
    done_d = 1'b0;
    erng_d = erng_q;
    eovf_d = eovf_q;
    case (state_q)
      RUN: if (acc) begin
        we_d = 1'b1;
        addr_d = ptr_q;
        wdata_d = enc;
        ptr_d = ptr_q + AW'(1);
        words_d = words_q + (AW+1)'(1);
        erng_d = erng_q || (rri && !in_rng);
        if (in_last) begin
`ifdef ENC_PAD_EN
          state_d = ptr_q != top_addr ? PAD : DONE;
`else
          state_d = DONE;
`endif
        end else if (ptr_q == top_addr) begin
          eovf_d = 1'b1;
          state_d = DONE;
        end
      end
`ifdef ENC_PAD_EN
      PAD: begin
        we_d = 1'b1;
        addr_d = ptr_q;
        wdata_d = 16'hE000;
        ptr_d = ptr_q + AW'(1);
        state_d = ptr_q == top_addr ? DONE : PAD;
      end
`endif
      DONE: begin
        // done is registered so it rises the cycle after the final write, never alongside it
        done_d = !start;
        if (start) begin
          state_d = RUN;
          ptr_d = '0;
          words_d = '0;
          erng_d = 1'b0;
          eovf_d = 1'b0;
        end
      end
      default: state_d = RUN;
    endcase
    rdy_d = state_d == RUN;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      ptr_q <= '0;
      words_q <= '0;
      we_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      rdy_q <= 1'b0;
      done_q <= 1'b0;
      erng_q <= 1'b0;
      eovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      words_q <= words_d;
      we_q <= we_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      rdy_q <= rdy_d;
      done_q <= done_d;
      erng_q <= erng_d;
      eovf_q <= eovf_d;
    end
  end
  assign in_ready = rdy_q;
  assign imem_we = we_q;
  assign imem_addr = addr_q;
  assign imem_wdata = wdata_q;
  assign done = done_q;
  assign words = words_q;
  assign err_range = erng_q;
  assign err_ovf = eovf_q;
endmodule

// File: tb/tb_instr_encoder_loader.sv
// tb_instr_encoder_loader: table vectors, hand sequences and a randomized model check of instr_encoder_loader
module tb_instr_encoder_loader;
`ifdef ENC_PAD_EN
  localparam bit PAD_EN = 1'b1;
`else
  localparam bit PAD_EN = 1'b0;
`endif
  logic clk = 0, rst = 1, start = 0, in_valid = 0, in_last = 0;
  logic [2:0] in_op = 0, in_ra = 0, in_rb = 0, in_rc = 0;
  logic [9:0] in_imm = 0;
  logic a_rdy, a_we, a_done, a_erng, a_eovf;
  logic [7:0] a_addr;
  logic [15:0] a_wdata;
  logic [8:0] a_words;
  logic b_rdy, b_we, b_done, b_erng, b_eovf;
  logic [2:0] b_addr;
  logic [15:0] b_wdata;
  logic [3:0] b_words;
  int checks = 0, failures = 0;
  instr_encoder_loader dut_a (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(a_rdy), .in_op(in_op),
    .in_ra(in_ra), .in_rb(in_rb), .in_rc(in_rc), .in_imm(in_imm), .in_last(in_last), .imem_we(a_we),
    .imem_addr(a_addr), .imem_wdata(a_wdata), .done(a_done), .words(a_words), .err_range(a_erng),
    .err_ovf(a_eovf)
  );
  instr_encoder_loader #(.DEPTH(8)) dut_b (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(b_rdy), .in_op(in_op),
    .in_ra(in_ra), .in_rb(in_rb), .in_rc(in_rc), .in_imm(in_imm), .in_last(in_last), .imem_we(b_we),
    .imem_addr(b_addr), .imem_wdata(b_wdata), .done(b_done), .words(b_words), .err_range(b_erng),
    .err_ovf(b_eovf)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [2:0] op, ra, rb, rc;
    logic [9:0] imm;
    logic [15:0] w;
    logic err;
  } vec_t;
  vec_t tbl[9];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  function automatic int simm(input logic [9:0] r);
    return r >= 10'd512 ? int'(r) - 1024 : int'(r);
  endfunction
  function automatic logic [15:0] model_word(input int op, input int ra, input int rb, input int rc,
                                             input logic [9:0] imm);
    int w;
    case (op)
      0, 1: w = op * 8192 + ra * 1024 + rb * 128 + rc;
      2: w = op * 8192 + ra * 1024 + int'(imm);
      3, 4, 5: w = op * 8192 + ra * 1024 + rb * 128 + ((simm(imm) % 128) + 128) % 128;
      6: w = 'hC000;
      default: w = 'hE000;
    endcase
    return w[15:0];
  endfunction
  function automatic bit model_rng(input int op, input logic [9:0] imm);
    return op >= 3 && op <= 5 && (simm(imm) < -64 || simm(imm) > 63);
  endfunction
  task automatic rand_fields;
    in_op = 3'($urandom_range(0, 7));
    in_ra = 3'($urandom_range(0, 7));
    in_rb = 3'($urandom_range(0, 7));
    in_rc = 3'($urandom_range(0, 7));
    in_imm = $urandom_range(0, 1) != 0 ? 10'($urandom_range(0, 1023)) : 10'($urandom_range(0, 127) - 64);
  endtask
  task automatic do_reset;
    rst = 1;
    in_valid = 0;
    start = 0;
    in_last = 0;
    tick;
    tick;
    chk("rst_ready", a_rdy, 0);
    chk("rst_we", a_we, 0);
    chk("rst_addr", a_addr, 0);
    chk("rst_wdata", a_wdata, 0);
    chk("rst_done", a_done, 0);
    chk("rst_words", a_words, 0);
    chk("rst_err_range", a_erng, 0);
    chk("rst_err_ovf", a_eovf, 0);
    chk("rst_b_we", b_we, 0);
    rst = 0;
    tick;
    chk("rel_ready_a", a_rdy, 1);
    chk("rel_ready_b", b_rdy, 1);
  endtask
  initial begin
    tbl[0] = '{3'd0, 3'd1, 3'd2, 3'd3, 10'h000, 16'h0503, 1'b0};
    tbl[1] = '{3'd1, 3'd4, 3'd5, 3'd6, 10'h3FF, 16'h3286, 1'b0};
    tbl[2] = '{3'd5, 3'd1, 3'd2, 3'd7, 10'h3FF, 16'hA57F, 1'b0};
    tbl[3] = '{3'd2, 3'd7, 3'd5, 3'd5, 10'h3FF, 16'h5FFF, 1'b0};
    tbl[4] = '{3'd4, 3'd3, 3'd4, 3'd0, 10'h3C0, 16'h8E40, 1'b0};
    tbl[5] = '{3'd6, 3'd7, 3'd7, 3'd7, 10'h3FF, 16'hC000, 1'b0};
    tbl[6] = '{3'd7, 3'd1, 3'd2, 3'd3, 10'h155, 16'hE000, 1'b0};
    tbl[7] = '{3'd3, 3'd0, 3'd0, 3'd0, 10'h040, 16'h6040, 1'b1};
    tbl[8] = '{3'd5, 3'd0, 3'd0, 3'd0, 10'h3BF, 16'hA03F, 1'b1};
    do_reset;
    for (int i = 0; i < 9; i++) begin
      {in_op, in_ra, in_rb, in_rc, in_imm} = {tbl[i].op, tbl[i].ra, tbl[i].rb, tbl[i].rc, tbl[i].imm};
      in_valid = 1;
      in_last = 0;
      tick;
      chk("tbl_we", a_we, 1);
      chk("tbl_addr", a_addr, i);
      chk("tbl_wdata", a_wdata, tbl[i].w);
      chk("tbl_words", a_words, i + 1);
      chk("tbl_err_range", a_erng, tbl[i].err);
    end
    in_valid = 0;
    start = 1;
    tick;
    start = 0;
    chk("start_in_run_words", a_words, 9);
    chk("start_in_run_ready", a_rdy, 1);
    chk("start_in_run_done", a_done, 0);
    in_op = 3'd7;
    in_valid = 1;
    in_last = 1;
    tick;
    in_valid = 0;
    in_last = 0;
    chk("last_we", a_we, 1);
    chk("last_addr", a_addr, 9);
    chk("last_wdata", a_wdata, 16'hE000);
    chk("last_done_early", a_done, 0);
    chk("last_ready", a_rdy, 0);
    tick;
    chk("done_we", a_we, 0);
    chk("done_high", a_done, 1);
    chk("done_ready", a_rdy, 0);
    chk("done_err_sticky", a_erng, 1);
    in_valid = 1;
    in_op = 3'd0;
    tick;
    in_valid = 0;
    chk("done_refuse_we", a_we, 0);
    chk("done_refuse_words", a_words, 10);
    start = 1;
    tick;
    start = 0;
    chk("rearm_done", a_done, 0);
    chk("rearm_err", a_erng, 0);
    chk("rearm_words", a_words, 0);
    chk("rearm_ready", a_rdy, 1);
    {in_op, in_ra, in_rb, in_rc} = {3'd0, 3'd1, 3'd2, 3'd3};
    in_valid = 1;
    tick;
    in_valid = 0;
    chk("rearm_addr", a_addr, 0);
    chk("rearm_wdata", a_wdata, 16'h0503);
    begin
      int m_ptr, m_cnt, m_last, m_pad, exp_addr;
      bit m_fin, m_err, acc, rng, exp_we, m_done;
      logic [15:0] exp_w, exp_wd;
      do_reset;
      m_ptr = 0; m_cnt = 0; m_last = 0; m_pad = 0; m_fin = 0; m_err = 0; exp_addr = 0; exp_wd = 0;
      for (int c = 0; c < 1500; c++) begin
        m_done = m_fin && m_cnt >= m_pad + 2;
        in_valid = $urandom_range(0, 9) < 7;
        rand_fields;
        in_last = m_ptr >= 250 || $urandom_range(0, 39) == 0;
        start = m_done ? $urandom_range(0, 2) == 0 :
                (!m_fin || m_cnt < m_pad + 1) && $urandom_range(0, 19) == 0;
        acc = in_valid && !m_fin;
        exp_w = model_word(in_op, in_ra, in_rb, in_rc, in_imm);
        rng = model_rng(in_op, in_imm);
        tick;
        if (start && m_done) begin
          m_fin = 0; m_ptr = 0; m_err = 0; m_cnt = 0; exp_we = 0;
        end else if (acc) begin
          exp_we = 1; exp_addr = m_ptr; exp_wd = exp_w;
          m_ptr++;
          m_err = m_err || rng;
          if (in_last) begin
            m_fin = 1; m_cnt = 1; m_last = m_ptr - 1; m_pad = PAD_EN ? 255 - m_last : 0;
          end
        end else if (m_fin) begin
          m_cnt++;
          exp_we = m_cnt <= m_pad + 1; exp_addr = m_last + m_cnt - 1; exp_wd = 16'hE000;
        end else exp_we = 0;
        chk("rnd_we", a_we, exp_we);
        if (exp_we) begin
          chk("rnd_addr", a_addr, exp_addr);
          chk("rnd_wdata", a_wdata, exp_wd);
        end
        chk("rnd_words", a_words, m_ptr);
        chk("rnd_err_range", a_erng, m_err);
        chk("rnd_done", a_done, m_fin && m_cnt >= m_pad + 2);
        chk("rnd_ready", a_rdy, !m_fin);
      end
      start = 0;
      in_valid = 0;
      in_last = 0;
    end
    begin
      logic [15:0] q[$];
      int nacc, nwr;
      do_reset;
      nacc = 0; nwr = 0;
      for (int c = 0; c < 14; c++) begin
        chk("ovf_ready", b_rdy, nacc < 8);
        in_valid = 1;
        rand_fields;
        in_last = 0;
        if (nacc < 8) begin
          q.push_back(model_word(in_op, in_ra, in_rb, in_rc, in_imm));
          nacc++;
        end
        tick;
        if (b_we) begin
          if (q.size() == 0) chk("ovf_extra_write", 1, 0);
          else begin
            chk("ovf_addr", b_addr, nwr);
            chk("ovf_wdata", b_wdata, q.pop_front());
          end
          nwr++;
        end
        chk("ovf_we_with_done", b_we && b_done, 0);
      end
      in_valid = 0;
      chk("ovf_writes", nwr, 8);
      chk("ovf_flag", b_eovf, 1);
      chk("ovf_done", b_done, 1);
      chk("ovf_ready_end", b_rdy, 0);
      chk("ovf_words", b_words, 8);
    end
    begin
      logic [15:0] q[$];
      int wcnt, lastw, donec;
      do_reset;
      wcnt = 0; lastw = -10; donec = -1;
      for (int c = 0; c < 30; c++) begin
        in_valid = c < 3;
        in_last = c == 2;
        if (c < 3) begin
          rand_fields;
          q.push_back(model_word(in_op, in_ra, in_rb, in_rc, in_imm));
        end
        tick;
        if (b_we) begin
          chk("pad_addr", b_addr, wcnt);
          chk("pad_wdata", b_wdata, q.size() != 0 ? q.pop_front() : 16'hE000);
          if (wcnt > 0) chk("pad_back_to_back", c, lastw + 1);
          lastw = c;
          wcnt++;
        end
        if (b_done && donec < 0) donec = c;
      end
      in_valid = 0;
      in_last = 0;
      chk("pad_write_count", wcnt, PAD_EN ? 8 : 3);
      chk("pad_done_cycle", donec, lastw + 1);
      chk("pad_words", b_words, 3);
      chk("pad_err_ovf", b_eovf, 0);
    end
    begin
      bit hit;
      int tgt;
      do_reset;
      hit = 0;
      tgt = PAD_EN ? 4 : 1;
      for (int c = 0; c < 20 && !hit; c++) begin
        in_valid = c < 3;
        in_last = c == 2;
        if (c < 3) rand_fields;
        tick;
        if (b_we && b_addr == 3'(tgt)) hit = 1;
      end
      in_valid = 0;
      in_last = 0;
      chk("padrst_reached", hit, 1);
      rst = 1;
      tick;
      chk("padrst_we", b_we, 0);
      chk("padrst_addr", b_addr, 0);
      chk("padrst_ready", b_rdy, 0);
      rst = 0;
      tick;
      chk("padrst_run_ready", b_rdy, 1);
      chk("padrst_words", b_words, 0);
      tick;
      tick;
      chk("padrst_no_more_writes", b_we, 0);
      chk("padrst_done", b_done, 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
